// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one request/ack memory port between the CPU IF and MEM
//            ports, with a starvation limit for IF and a pipeline stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic [1:0]        grant_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_DM = 2'd2;

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [3:0] r_starve_cnt;
    logic       w_if_elig;
    logic       w_dm_elig;
    logic       w_grant_if;
    logic       w_grant_dm;
    logic       w_if_done;
    logic       w_dm_done;

    // A request still high during its own ack cycle belongs to the finished
    // transaction, so it must not win a new grant.
    assign w_if_elig = if_req_i & ~if_ack_o;
    assign w_dm_elig = dm_req_i & ~dm_ack_o;

    assign w_if_done = (r_state == S_BUSY_IF) & mem_ack_i;
    assign w_dm_done = (r_state == S_BUSY_DM) & mem_ack_i;

    assign stall_o = w_if_elig | w_dm_elig;

    always_comb begin
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        if (r_state == S_IDLE) begin
            if (w_dm_elig && (!w_if_elig || (r_starve_cnt < C_STARVE_MAX))) begin
                w_grant_dm = 1'b1;
            end else if (w_if_elig) begin
                w_grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_dm) begin
                    w_next_state = S_BUSY_DM;
                end else if (w_grant_if) begin
                    w_next_state = S_BUSY_IF;
                end
            end
            S_BUSY_IF,
            S_BUSY_DM: begin
                if (mem_ack_i) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        grant_o = 2'b00;
        case (r_state)
            S_BUSY_IF: grant_o = 2'b01;
            S_BUSY_DM: grant_o = 2'b10;
            default:   grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            if_ack_o     <= 1'b0;
            dm_ack_o     <= 1'b0;
            if_data_o    <= '0;
            dm_rdata_o   <= '0;
            r_starve_cnt <= 4'd0;
        end else begin
            if_ack_o <= w_if_done;
            dm_ack_o <= w_dm_done;

            if (w_grant_if) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr_i;
                mem_wdata_o <= '0;
            end else if (w_grant_dm) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= dm_we_i;
                mem_addr_o  <= dm_addr_i;
                mem_wdata_o <= dm_wdata_i;
            end else if (w_if_done || w_dm_done) begin
                mem_req_o <= 1'b0;
            end

            if (w_if_done) begin
                if_data_o <= mem_rdata_i;
            end
            if (w_dm_done && !mem_we_o) begin
                dm_rdata_o <= mem_rdata_i;
            end

            if (w_grant_if) begin
                r_starve_cnt <= 4'd0;
            end else if (w_grant_dm && w_if_elig && (r_starve_cnt < C_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed-vector bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_ack_o;
    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic              stall_o;
    logic [1:0]        grant_o;

    logic auto_ack;
    logic man_ack;
    int   vectors     = 0;
    int   miscompares = 0;

    // Zero-wait memory answers in the first cycle of a request.
    assign mem_ack_i = auto_ack ? mem_req_o : man_ack;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .grant_o(grant_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0; auto_ack = 0; man_ack = 0;
        tick(); tick();
        vectors++; if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req_o); end
        vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL rst_grant got=%0b exp=00", grant_o); end
        vectors++; if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_acks got=%0b%0b exp=00", if_ack_o, dm_ack_o); end
        vectors++; if (if_data_o !== '0 || dm_rdata_o !== '0) begin miscompares++; $display("FAIL rst_data got=%h/%h exp=0/0", if_data_o, dm_rdata_o); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%0b exp=0", stall_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_if_read;
        auto_ack = 1; mem_rdata_i = 32'hDEADBEEF;
        if_req_i = 1; if_addr_i = 32'h10;
        #1;
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL ifrd_stall_c0 got=%0b exp=1", stall_o); end
        tick();
        vectors++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin miscompares++; $display("FAIL ifrd_memreq_c1 got=%0b/%h exp=1/00000010", mem_req_o, mem_addr_o); end
        vectors++; if (mem_we_o !== 1'b0 || grant_o !== 2'b01) begin miscompares++; $display("FAIL ifrd_we_grant_c1 got=%0b/%0b exp=0/01", mem_we_o, grant_o); end
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL ifrd_stall_c1 got=%0b exp=1", stall_o); end
        tick();
        vectors++; if (if_ack_o !== 1'b1 || if_data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ifrd_ack_c2 got=%0b/%h exp=1/deadbeef", if_ack_o, if_data_o); end
        vectors++; if (stall_o !== 1'b0 || grant_o !== 2'b00 || mem_req_o !== 1'b0) begin miscompares++; $display("FAIL ifrd_idle_c2 got=%0b/%0b/%0b exp=0/00/0", stall_o, grant_o, mem_req_o); end
        if_req_i = 0;
        tick();
        vectors++; if (if_ack_o !== 1'b0) begin miscompares++; $display("FAIL ifrd_ack_single got=%0b exp=0", if_ack_o); end
    endtask

    task automatic test_dm_write_wait;
        auto_ack = 0; man_ack = 0; mem_rdata_i = 32'h12345678;
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h20; dm_wdata_i = 32'h5A;
        for (int c = 1; c <= 4; c++) begin
            tick();
            vectors++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || dm_ack_o !== 1'b0) begin miscompares++; $display("FAIL dmwr_hold_c%0d got=%0b/%0b/%0b exp=1/1/0", c, mem_req_o, mem_we_o, dm_ack_o); end
            if (c == 4) man_ack = 1;
        end
        vectors++; if (mem_addr_o !== 32'h20 || mem_wdata_o !== 32'h5A) begin miscompares++; $display("FAIL dmwr_addr_data got=%h/%h exp=00000020/0000005a", mem_addr_o, mem_wdata_o); end
        tick();
        man_ack = 0;
        vectors++; if (dm_ack_o !== 1'b1 || mem_req_o !== 1'b0) begin miscompares++; $display("FAIL dmwr_ack_c5 got=%0b/%0b exp=1/0", dm_ack_o, mem_req_o); end
        vectors++; if (dm_rdata_o !== 32'h0) begin miscompares++; $display("FAIL dmwr_rdata_kept got=%h exp=00000000", dm_rdata_o); end
        dm_req_i = 0; dm_we_i = 0;
        tick();
        vectors++; if (dm_ack_o !== 1'b0) begin miscompares++; $display("FAIL dmwr_ack_single got=%0b exp=0", dm_ack_o); end
    endtask

    // Both requests are re-presented each round in an idle cycle so that both
    // are eligible at every grant edge; the starvation limit then forces IF.
    task automatic test_starvation;
        logic [1:0] exp_grant [6];
        exp_grant = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        auto_ack = 1; dm_we_i = 0;
        for (int i = 0; i < 6; i++) begin
            if_req_i = 1; dm_req_i = 1;
            if_addr_i = 32'h100 + i; dm_addr_i = 32'h200 + i;
            mem_rdata_i = 32'hA5A50000 + i;
            tick();
            vectors++; if (grant_o !== exp_grant[i]) begin miscompares++; $display("FAIL starve_grant_%0d got=%0b exp=%0b", i, grant_o, exp_grant[i]); end
            vectors++; if (mem_addr_o !== ((exp_grant[i] == 2'b01) ? 32'h100 + i : 32'h200 + i)) begin miscompares++; $display("FAIL starve_addr_%0d got=%h", i, mem_addr_o); end
            if_req_i = 0; dm_req_i = 0;
            tick();
            vectors++; if ({dm_ack_o, if_ack_o} !== exp_grant[i]) begin miscompares++; $display("FAIL starve_ack_%0d got=%0b%0b exp=%0b", i, dm_ack_o, if_ack_o, exp_grant[i]); end
            tick();
        end
    endtask

    task automatic test_ack_mask;
        int acks;
        acks = 0;
        auto_ack = 1; mem_rdata_i = 32'hCAFE0001;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h30;
        tick();
        vectors++; if (grant_o !== 2'b10) begin miscompares++; $display("FAIL mask_grant_c1 got=%0b exp=10", grant_o); end
        tick();
        vectors++; if (dm_ack_o !== 1'b1 || dm_rdata_o !== 32'hCAFE0001) begin miscompares++; $display("FAIL mask_ack_c2 got=%0b/%h exp=1/cafe0001", dm_ack_o, dm_rdata_o); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL mask_stall_c2 got=%0b exp=0", stall_o); end
        if (dm_ack_o) acks++;
        tick();
        vectors++; if (grant_o !== 2'b00 || mem_req_o !== 1'b0) begin miscompares++; $display("FAIL mask_no_regrant got=%0b/%0b exp=00/0", grant_o, mem_req_o); end
        dm_req_i = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (dm_ack_o) acks++;
        end
        vectors++; if (acks !== 1) begin miscompares++; $display("FAIL mask_ack_count got=%0d exp=1", acks); end
    endtask

    task automatic test_reset_mid;
        auto_ack = 0; man_ack = 0;
        dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h44; dm_wdata_i = 32'h77;
        tick();
        vectors++; if (mem_req_o !== 1'b1 || grant_o !== 2'b10) begin miscompares++; $display("FAIL rmid_busy got=%0b/%0b exp=1/10", mem_req_o, grant_o); end
        rst_i = 1;
        tick();
        vectors++; if ({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, grant_o} !== 6'b0) begin miscompares++; $display("FAIL rmid_ctrl got=%0b%0b%0b%0b%0b exp=000000", mem_req_o, mem_we_o, if_ack_o, dm_ack_o, grant_o); end
        vectors++; if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin miscompares++; $display("FAIL rmid_bus got=%h/%h exp=0/0", mem_addr_o, mem_wdata_o); end
        vectors++; if (if_data_o !== '0 || dm_rdata_o !== '0) begin miscompares++; $display("FAIL rmid_data got=%h/%h exp=0/0", if_data_o, dm_rdata_o); end
        rst_i = 0; dm_req_i = 0; dm_we_i = 0; man_ack = 1; mem_rdata_i = 32'hBAD0BAD0;
        tick();
        man_ack = 0;
        vectors++; if (dm_ack_o !== 1'b0 || if_ack_o !== 1'b0 || grant_o !== 2'b00 || mem_req_o !== 1'b0) begin miscompares++; $display("FAIL rmid_late_ack got=%0b/%0b/%0b/%0b exp=0/0/00/0", dm_ack_o, if_ack_o, grant_o, mem_req_o); end
        vectors++; if (dm_rdata_o !== '0) begin miscompares++; $display("FAIL rmid_late_data got=%h exp=0", dm_rdata_o); end
        tick();
    endtask

    task automatic test_spurious_ack;
        auto_ack = 1; mem_rdata_i = 32'h11112222;
        if_req_i = 1; if_addr_i = 32'h50;
        tick(); tick();
        vectors++; if (if_data_o !== 32'h11112222) begin miscompares++; $display("FAIL spur_setup got=%h exp=11112222", if_data_o); end
        if_req_i = 0;
        tick();
        auto_ack = 0; man_ack = 1; mem_rdata_i = 32'h99999999;
        tick(); tick();
        man_ack = 0;
        vectors++; if (if_ack_o !== 1'b0 || dm_ack_o !== 1'b0 || grant_o !== 2'b00) begin miscompares++; $display("FAIL spur_ack got=%0b/%0b/%0b exp=0/0/00", if_ack_o, dm_ack_o, grant_o); end
        vectors++; if (if_data_o !== 32'h11112222 || dm_rdata_o !== '0) begin miscompares++; $display("FAIL spur_data got=%h/%h exp=11112222/0", if_data_o, dm_rdata_o); end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_dm_write_wait();
        test_starvation();
        test_ack_mask();
        test_reset_mid();
        test_spurious_ack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter sharing one off-chip memory port between the pipelined CPU's instruction-fetch (IF) port and data-memory (MEM-stage) port. It grants one requester at a time and drives a single request/acknowledge memory interface. It raises a pipeline stall while either requester is waiting. It replaces the separate instruction and data memories when both are backed by one unified memory.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_MAX, 4, consecutive data grants allowed while IF waits; 1..15

- clk_i  in  1  clock; all logic on the rising edge
- rst_i  in  1  synchronous reset, active-high
- if_req_i  in  1  IF read request; level, held until if_ack_o
- if_addr_i  in  ADDR_W  IF read address
- if_data_o  out  DATA_W  IF read data; valid when if_ack_o=1, holds until the next IF read completes
- if_ack_o  out  1  one-cycle completion pulse for IF
- dm_req_i  in  1  data request; level, held until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data; valid when dm_ack_o=1, unchanged by writes
- dm_ack_o  out  1  one-cycle completion pulse for data
- mem_req_o  out  1  memory request; held until mem_ack_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data; valid with mem_ack_i
- mem_ack_i  in  1  memory completion; may arrive in the first cycle mem_req_o is high
- stall_o  out  1  combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o)
- grant_o  out  2  current owner: 00 none, 01 IF, 10 data

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - Eligible requesters are if_req_i & ~if_ack_o and dm_req_i & ~dm_ack_o. A requester is masked during its own ack cycle.
  - Data only -> BUSY_DM.
  - IF only -> BUSY_IF.
  - Both -> BUSY_DM if starve_cnt < STARVE_MAX, else BUSY_IF.
- On entering BUSY_x: register mem_req_o=1, mem_addr_o, mem_we_o, and mem_wdata_o from requester x. For IF, mem_we_o=0 and mem_wdata_o=0.
- Inputs are ignored while in BUSY_x. A requester dropping req mid-transaction does not abort it; the ack is still pulsed.
- BUSY_x with mem_ack_i=1 at the edge:
  - mem_req_o→0, state→IDLE, x_ack_o=1 for exactly one cycle.
  - For a read, capture mem_rdata_i into x_data_o / dm_rdata_o.
- BUSY_x with mem_ack_i=0: stay in the state; memory outputs are held stable.
- starve_cnt is 4 bits:
  - Cleared on an IF grant.
  - Incremented, saturating at STARVE_MAX, on a data grant while if_req_i is eligible.
  - Unchanged otherwise.
- mem_ack_i while IDLE is ignored (spurious).
- Reset (any state, including mid-transaction):
  - State IDLE, starve_cnt 0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, dm_ack_o, if_data_o, dm_rdata_o, and grant_o all 0.
  - The in-flight memory transaction is abandoned; a late mem_ack_i after reset is ignored.

## Timing
- Request seen at edge N (state IDLE) -> mem_req_o high from cycle N+1.
- mem_ack_i sampled at edge M ≥ N+1 -> ack_o pulses in cycle M+1 and the state returns to IDLE in that same cycle.
- Minimum latency: request cycle 0 to ack in cycle 2, for zero-wait memory.
- Back-to-back: the next grant edge is the one ending the ack cycle. Maximum memory utilisation is therefore one transaction per 2 cycles plus memory wait.
- grant_o reflects the state register: 01 in BUSY_IF, 10 in BUSY_DM, 00 in IDLE.
- stall_o has no register delay. It is low in a requester's ack cycle unless the other requester is waiting.

## Test plan
- Single IF read, zero-wait memory: if_req_i=1 with addr 0x10 at cycle 0, mem_rdata_i=0xDEADBEEF.
  - Required: mem_req_o in cycle 1 with addr 0x10, if_ack_o in cycle 2, if_data_o=0xDEADBEEF, stall_o=1 in cycles 0–1 and 0 in cycle 2.
- Data write with 3-cycle memory wait: dm_we_i=1, addr 0x20, wdata 0x5A.
  - Required: mem_we_o=1 held in cycles 1–4 with mem_ack_i in cycle 4.
  - dm_ack_o in cycle 5; dm_rdata_o unchanged.
- Both requesting continuously, STARVE_MAX=4, zero-wait memory:
  - Required grant order D, D, D, D, IF, D, …; starve_cnt clears after the IF grant.
- Ack masking: hold dm_req_i high through its ack cycle.
  - Required: no second data grant issued from the ack cycle; one transaction only.
- Reset mid-transaction: rst_i in BUSY_DM before mem_ack_i, then a late mem_ack_i after reset.
  - Required: all outputs 0 the cycle after reset, no ack pulse, state IDLE.
- Spurious mem_ack_i in IDLE with no requests.
  - Required: no ack_o pulse, no data register change.
